// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// The assembled word is offered on a valid/ready buffer; errors and overruns are one-cycle pulses.
module serial_frame_receiver #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SI,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  // state  | meaning
  // IDLE   | waiting for a start bit (SI=1)
  // DATA   | shifting in DATA_W data bits, LSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit and classifying the frame
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  state_t             state;
  logic [DATA_W-1:0]  sr;
  logic [CNT_W-1:0]   cnt;
  logic               par_acc;
  logic               par_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (valid && ready)
        valid <= 1'b0;

      case (state)
        IDLE: begin
          if (SI) begin
            cnt     <= '0;
            par_acc <= 1'b0;
            par_bad <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          sr      <= {SI, sr[DATA_W-1:1]};
          cnt     <= cnt + 1'b1;
          par_acc <= par_acc ^ SI;
          if (cnt == CNT_W'(DATA_W - 1))
            state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          par_bad <= (SI != par_acc);
          state   <= STOP;
        end
        STOP: begin
          state <= IDLE;
          // A bad stop bit outranks a parity error; a good word may load into a buffer being drained now.
          if (SI)
            frame_err <= 1'b1;
          else if (par_bad)
            parity_err <= 1'b1;
          else if (!valid || ready) begin
            data_out <= sr;
            valid    <= 1'b1;
          end else
            overrun <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Downstream consumer of the right-shift register's serial output (`SO`). It detects a start bit on its serial input and shifts in `DATA_W` data bits LSB-first, matching the right-shift order. It then checks an optional even-parity bit and a stop bit, and presents the assembled word on a valid/ready parallel interface. Framing and parity failures are reported as one-cycle pulses, and so is a word lost because the output buffer was still full.

## Interface
- `DATA_W`, default 8: data bits per frame (≥2).
- `PARITY_EN`, default 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `SI`  in  1: serial input, one bit per `clk`; idle level 0.
- `data_out`  out  DATA_W: received word; stable while `valid`=1.
- `valid`  out  1: `data_out` holds an unread word.
- `ready`  in  1: consumer accepts the word when `valid`&&`ready` at a rising edge.
- `frame_err`  out  1: one-cycle pulse; stop bit was 1.
- `parity_err`  out  1: one-cycle pulse; parity mismatch.
- `overrun`  out  1: one-cycle pulse; a good frame was dropped because the buffer was full.

## Operation
- **FSM states:** IDLE, DATA, PARITY, STOP.
- **Reset:** while `rst`=0:
  - state = IDLE; shift register, bit counter and `data_out` all = 0.
  - `valid`, `frame_err`, `parity_err`, `overrun` = 0.
  - Applies immediately, regardless of `clk`; a partial frame is discarded.
- **IDLE:** `SI`=1 sampled means start bit; clear bit counter and go to DATA. `SI`=0 means stay.
- **DATA:**
  - Each cycle: `sr <= {SI, sr[DATA_W-1:1]}`, counter+1, accumulate XOR of `SI`.
  - After the `DATA_W`-th bit, go to PARITY if `PARITY_EN`=1, else STOP.
  - The first data bit received ends in `data_out[0]`.
- **PARITY:** sample `SI`. Error if `SI` ≠ XOR of the data bits (even parity over data+parity bit). Record the error; go to STOP.
- **STOP:** sample `SI`, then always return to IDLE. The frame is classified in this priority order:
  - `SI`=1: pulse `frame_err`; word discarded; parity result ignored.
  - Parity error recorded: pulse `parity_err`; word discarded.
  - Otherwise the frame is good:
    - If `valid`=0, or `valid`&&`ready` this same cycle: load `data_out` and set `valid`=1.
    - Else: pulse `overrun`; the old word is kept unchanged.
- **Output buffer:**
  - `valid` clears on `valid`&&`ready`, unless a good frame loads in the same cycle, in which case `valid` stays 1 with the new data.
  - `ready` is ignored when `valid`=0.
- A start bit only counts in IDLE; `SI` activity while already in a frame is data, parity or stop.
- At most one error/overrun pulse per frame.

## Timing
- **Frame length:** 1 + `DATA_W` + `PARITY_EN` + 1 cycles.
- **Edge numbering:** start bit sampled at edge k; data bits at edges k+1 … k+`DATA_W`; parity at k+`DATA_W`+1 (if enabled); stop at edge s = k+`DATA_W`+`PARITY_EN`+1.
- **Outputs:** `valid`/`data_out` or the error pulse appear after edge s and last exactly one cycle (pulses) or until accepted (`valid`).
- **Back-to-back frames:** earliest next start bit is sampled at edge s+1; there is no dead cycle.
- **Latency:** last data bit to `valid` is 1 + `PARITY_EN` cycles.
- **Handshake:**
  - Transfer happens on the edge where `valid`&&`ready` is sampled.
  - `valid` drops after that edge unless refilled.
  - No combinational path from `ready` to any output.
- **Mid-frame reset:** outputs return to reset values asynchronously. After release, the first rising edge with `SI`=1 in IDLE starts a new frame.

## Test plan
All scenarios use `DATA_W`=8, `PARITY_EN`=1.
- **Reset values:** hold `rst`=0 for 2 cycles with `SI` toggling → all outputs 0, no `valid`. Release, keep `SI`=0 for 5 cycles → still idle.
- **Good frame:**
  - Stimulus: `SI` sequence 1 (start), 1,0,1,0,0,1,0,1 (0xA5 LSB-first), 0 (parity), 0 (stop); `ready`=1.
  - Response: `valid`=1 for one cycle after the stop edge, with `data_out`=0xA5; no error pulses.
- **Parity error:** as the good frame but parity bit 1 → `parity_err` pulses once, `valid` stays 0, `data_out` unchanged.
- **Frame error:** 0x3C with correct parity 0 but stop bit 1 → `frame_err` pulses once, `valid`=0. An immediately following good frame 0x01 (start,1,0,0,0,0,0,0,0,parity 1,stop 0) is received correctly.
- **Overrun:**
  - Hold `ready`=0; send 0x11 then 0x22 back-to-back.
  - After frame 1: `valid`=1, `data_out`=0x11.
  - After frame 2: `overrun` pulses; `data_out` is still 0x11.
  - Raising `ready` then clears `valid` after one edge.
- **Mid-frame reset / simultaneous accept:**
  - Assert `rst`=0 after 4 data bits → state clears immediately; no spurious `valid` after release.
  - Separately: with `valid`=1 (0x55 pending), assert `ready` on the stop edge of frame 0xAA → `valid` stays 1, `data_out`=0xAA, no `overrun`.
